// File: rtl/i2c_pkg.sv
// Shared command/state types and phase-threshold helpers for the I2C bit sequencer.
package i2c_pkg;

  localparam int TIMER_WIDTH_DEFAULT = 8;
  localparam int MIN_PHASE_CYCLES    = 2;

  typedef enum logic [1:0] {
    CMD_START = 2'd0,
    CMD_STOP  = 2'd1,
    CMD_WRITE = 2'd2,
    CMD_READ  = 2'd3
  } cmd_e;

  typedef enum logic [3:0] {
    S_IDLE       = 4'd0,
    S_LOW_START  = 4'd1,
    S_LOW_A      = 4'd2,
    S_LOW_B      = 4'd3,
    S_SCL_WAIT   = 4'd4,
    S_HIGH_START = 4'd5,
    S_HIGH_A     = 4'd6,
    S_HIGH_B     = 4'd7
  } seq_state_e;

  // A phase shorter than two cycles leaves no room for the mid-phase event.
  function automatic logic [31:0] clamp_phase(input logic [31:0] t);
    return (t < 32'(MIN_PHASE_CYCLES)) ? 32'(MIN_PHASE_CYCLES) : t;
  endfunction

  function automatic logic [31:0] half_phase(input logic [31:0] t);
    return t >> 1;
  endfunction

endpackage

// File: rtl/i2c_sync2.sv
// Two-flop synchroniser for a raw bus level; resets to the idle (released) level.
module i2c_sync2 #(
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clock_i,
  input  logic reset_i,
  input  logic d_i,
  output logic q_o
);

  logic r_meta;
  logic r_sync;

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      r_meta <= RESET_VAL;
      r_sync <= RESET_VAL;
    end else begin
      r_meta <= d_i;
      r_sync <= r_meta;
    end
  end

  assign q_o = r_sync;

endmodule

// File: rtl/i2c_bit_sequencer.sv
// Bit-level I2C phase controller driving an external two-interrupt multitimer.
// Optional clock stretching (SCL_WAIT state) is enabled with `define I2C_CLOCK_STRETCH_EN.
module i2c_bit_sequencer
  import i2c_pkg::*;
#(
  parameter int TIMER_WIDTH = TIMER_WIDTH_DEFAULT
) (
  input  logic                       clock_i,
  input  logic                       reset_i,
  input  logic                       cmd_valid_i,
  output logic                       cmd_ready_o,
  input  logic [1:0]                 cmd_i,
  input  logic                       cmd_data_i,
  input  logic [TIMER_WIDTH-1:0]     t_low_i,
  input  logic [TIMER_WIDTH-1:0]     t_high_i,
  output logic                       rsp_valid_o,
  output logic                       rsp_data_o,
  output logic                       rsp_arb_lost_o,
  output logic                       busy_o,
  output logic [2*TIMER_WIDTH-1:0]   timer_set_o,
  output logic                       timer_start_o,
  input  logic [1:0]                 expired_i,
  input  logic                       scl_i,
  input  logic                       sda_i,
  output logic                       scl_oe_o,
  output logic                       sda_oe_o
);

  seq_state_e                 r_state,      w_state_nxt;
  cmd_e                       r_cmd,        w_cmd_nxt;
  logic                       r_bit,        w_bit_nxt;
  logic [TIMER_WIDTH-1:0]     r_t_high,     w_t_high_nxt;
  logic [2*TIMER_WIDTH-1:0]   r_timer_set,  w_timer_set_nxt;
  logic                       r_scl_oe,     w_scl_oe_nxt;
  logic                       r_sda_oe,     w_sda_oe_nxt;
  logic                       r_rsp_valid,  w_rsp_valid_nxt;
  logic                       r_rsp_arb,    w_rsp_arb_nxt;
  logic                       r_rsp_data,   w_rsp_data_nxt;

  logic                       w_arb_lost;
  logic                       w_scl_sync;
  logic                       w_sda_sync;
  logic [TIMER_WIDTH-1:0]     w_t_low_c;
  logic [TIMER_WIDTH-1:0]     w_t_low_half;
  logic [TIMER_WIDTH-1:0]     w_t_high_c;
  logic [TIMER_WIDTH-1:0]     w_t_high_half;

  i2c_sync2 #(.RESET_VAL(1'b1)) u_scl_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (scl_i),
    .q_o     (w_scl_sync)
  );

  i2c_sync2 #(.RESET_VAL(1'b1)) u_sda_sync (
    .clock_i (clock_i),
    .reset_i (reset_i),
    .d_i     (sda_i),
    .q_o     (w_sda_sync)
  );

`ifndef I2C_CLOCK_STRETCH_EN
  // Without stretching the synchronised SCL level has no consumer.
  logic w_unused_scl_sync;
  assign w_unused_scl_sync = w_scl_sync;
`endif

  assign w_t_low_c     = TIMER_WIDTH'(clamp_phase(32'(t_low_i)));
  assign w_t_low_half  = TIMER_WIDTH'(half_phase(32'(w_t_low_c)));
  assign w_t_high_c    = TIMER_WIDTH'(clamp_phase(32'(t_high_i)));
  assign w_t_high_half = TIMER_WIDTH'(half_phase(32'(r_t_high)));

  always_comb begin
    // NOTE: every next-value is defaulted first, so no path through the case infers a latch.
    w_state_nxt     = r_state;
    w_cmd_nxt       = r_cmd;
    w_bit_nxt       = r_bit;
    w_t_high_nxt    = r_t_high;
    w_timer_set_nxt = r_timer_set;
    w_scl_oe_nxt    = r_scl_oe;
    w_sda_oe_nxt    = r_sda_oe;
    w_rsp_valid_nxt = 1'b0;
    w_rsp_arb_nxt   = 1'b0;
    w_rsp_data_nxt  = r_rsp_data;
    w_arb_lost      = 1'b0;

    unique case (r_state)
      S_IDLE: begin
        if (cmd_valid_i) begin
          w_cmd_nxt       = cmd_e'(cmd_i);
          w_bit_nxt       = cmd_data_i;
          w_t_high_nxt    = w_t_high_c;
          w_timer_set_nxt = {w_t_low_c, w_t_low_half};
          w_scl_oe_nxt    = 1'b1;
          w_state_nxt     = S_LOW_START;
        end
      end

      // Expired flags still reflect the previous phase during the start cycle.
      S_LOW_START: w_state_nxt = S_LOW_A;

      S_LOW_A: begin
        if (expired_i[0]) begin
          unique case (r_cmd)
            CMD_STOP:  w_sda_oe_nxt = 1'b1;
            CMD_WRITE: w_sda_oe_nxt = ~r_bit;
            default:   w_sda_oe_nxt = 1'b0;
          endcase
          w_state_nxt = S_LOW_B;
        end
      end

      S_LOW_B: begin
        if (expired_i[1]) begin
          w_scl_oe_nxt    = 1'b0;
          w_timer_set_nxt = {r_t_high, w_t_high_half};
`ifdef I2C_CLOCK_STRETCH_EN
          w_state_nxt     = S_SCL_WAIT;
`else
          w_state_nxt     = S_HIGH_START;
`endif
        end
      end

      S_SCL_WAIT: begin
`ifdef I2C_CLOCK_STRETCH_EN
        if (w_scl_sync) w_state_nxt = S_HIGH_START;
`else
        w_state_nxt = S_HIGH_START;
`endif
      end

      S_HIGH_START: w_state_nxt = S_HIGH_A;

      S_HIGH_A: begin
        if (expired_i[0]) begin
          w_rsp_data_nxt = w_sda_sync;
          unique case (r_cmd)
            CMD_START: begin
              if (!w_sda_sync) w_arb_lost = 1'b1;
              else             w_sda_oe_nxt = 1'b1;
            end
            CMD_STOP:  w_sda_oe_nxt = 1'b0;
            CMD_WRITE: w_arb_lost   = r_bit & ~w_sda_sync;
            default:   w_sda_oe_nxt = r_sda_oe;
          endcase
          if (w_arb_lost) begin
            // Give the bus away immediately: both lines released, report and go idle.
            w_scl_oe_nxt    = 1'b0;
            w_sda_oe_nxt    = 1'b0;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_arb_nxt   = 1'b1;
            w_state_nxt     = S_IDLE;
          end else begin
            w_state_nxt     = S_HIGH_B;
          end
        end
      end

      S_HIGH_B: begin
        if (expired_i[1]) begin
          w_scl_oe_nxt    = (r_cmd != CMD_STOP);
          w_rsp_valid_nxt = 1'b1;
          w_state_nxt     = S_IDLE;
        end
      end

      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clock_i) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (reset_i) begin
      r_state     <= S_IDLE;
      r_cmd       <= CMD_START;
      r_bit       <= 1'b0;
      r_t_high    <= '0;
      r_timer_set <= '1;
      r_scl_oe    <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_arb   <= 1'b0;
      r_rsp_data  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cmd       <= w_cmd_nxt;
      r_bit       <= w_bit_nxt;
      r_t_high    <= w_t_high_nxt;
      r_timer_set <= w_timer_set_nxt;
      r_scl_oe    <= w_scl_oe_nxt;
      r_sda_oe    <= w_sda_oe_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_arb   <= w_rsp_arb_nxt;
      r_rsp_data  <= w_rsp_data_nxt;
    end
  end

  assign cmd_ready_o    = (r_state == S_IDLE);
  assign busy_o         = (r_state != S_IDLE);
  assign timer_start_o  = (r_state == S_LOW_START) || (r_state == S_HIGH_START);
  assign timer_set_o    = r_timer_set;
  assign scl_oe_o       = r_scl_oe;
  assign sda_oe_o       = r_sda_oe;
  assign rsp_valid_o    = r_rsp_valid;
  assign rsp_arb_lost_o = r_rsp_arb;
  assign rsp_data_o     = r_rsp_data;

endmodule
